datapath_controller: RTL and testbench



---
 rtl/datapath_ctrl_pkg.sv | 71 +++++++
 rtl/instr_decoder.sv | 37 +++
 rtl/datapath_controller.sv | 157 +++++++++++++++
 tb/tb_datapath_controller.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_ctrl_pkg.sv
// Shared types and constants for the datapath controller and its decoder.
package datapath_ctrl_pkg;

    localparam int unsigned PC_W      = 8;
    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned REG_SEL_W = 4;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned IMM_W     = 8;

    localparam logic [OP_W-1:0] OP_PASS_B = 4'b1100;

    localparam logic [3:0] OPC_LDI  = 4'h8;
    localparam logic [3:0] OPC_LD   = 4'h9;
    localparam logic [3:0] OPC_ST   = 4'hA;
    localparam logic [3:0] OPC_BZ   = 4'hB;
    localparam logic [3:0] OPC_BNZ  = 4'hC;
    localparam logic [3:0] OPC_JMP  = 4'hD;
    localparam logic [3:0] OPC_HALT = 4'hE;
    localparam logic [3:0] OPC_NOP  = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_EXEC     = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } state_e;

    typedef enum logic [3:0] {
        CLS_NOP  = 4'd0,
        CLS_ALU  = 4'd1,
        CLS_LDI  = 4'd2,
        CLS_LD   = 4'd3,
        CLS_ST   = 4'd4,
        CLS_BZ   = 4'd5,
        CLS_BNZ  = 4'd6,
        CLS_JMP  = 4'd7,
        CLS_HALT = 4'd8
    } instr_class_e;

    // Decoded view of the instruction register.
    typedef struct packed {
        instr_class_e         cls;
        logic [2:0]           alu_op;
        logic [REG_SEL_W-1:0] rd;
        logic [REG_SEL_W-1:0] ra;
        logic [REG_SEL_W-1:0] rb;
        logic [IMM_W-1:0]     imm8;
    } decoded_t;

    function automatic logic [3:0] instr_opc(input logic [INSTR_W-1:0] instr);
        return instr[15:12];
    endfunction

    function automatic logic [REG_SEL_W-1:0] instr_rd(input logic [INSTR_W-1:0] instr);
        return instr[11:8];
    endfunction

    function automatic logic [REG_SEL_W-1:0] instr_ra(input logic [INSTR_W-1:0] instr);
        return instr[7:4];
    endfunction

    function automatic logic [REG_SEL_W-1:0] instr_rb(input logic [INSTR_W-1:0] instr);
        return instr[3:0];
    endfunction

    function automatic logic [IMM_W-1:0] instr_imm8(input logic [INSTR_W-1:0] instr);
        return instr[7:0];
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: splits IR into class and operand fields.
module instr_decoder
    import datapath_ctrl_pkg::*;
(
    input  logic [INSTR_W-1:0] ir,
    output decoded_t           dec_c
);

    logic [3:0] opc;

    assign opc = instr_opc(ir);

    // Field extraction and opcode classification
    always_comb begin
        dec_c        = '0;
        dec_c.alu_op = opc[2:0];
        dec_c.rd     = instr_rd(ir);
        dec_c.ra     = instr_ra(ir);
        dec_c.rb     = instr_rb(ir);
        dec_c.imm8   = instr_imm8(ir);
        if (!opc[3]) begin
            dec_c.cls = CLS_ALU;
        end else begin
            case (opc)
                OPC_LDI:  dec_c.cls = CLS_LDI;
                OPC_LD:   dec_c.cls = CLS_LD;
                OPC_ST:   dec_c.cls = CLS_ST;
                OPC_BZ:   dec_c.cls = CLS_BZ;
                OPC_BNZ:  dec_c.cls = CLS_BNZ;
                OPC_JMP:  dec_c.cls = CLS_JMP;
                OPC_HALT: dec_c.cls = CLS_HALT;
                default:  dec_c.cls = CLS_NOP;
            endcase
        end
    end

endmodule

// File: rtl/datapath_controller.sv
// Multi-cycle fetch/execute sequencer driving the control inputs of the datapath.
module datapath_controller
    import datapath_ctrl_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    output logic [PC_W-1:0]      INSTR_ADDR,
    output logic                 INSTR_REQ,
    input  logic [INSTR_W-1:0]   INSTR_IN,
    input  logic                 INSTR_VALID,
    input  logic                 Z,
    output logic [REG_SEL_W-1:0] A_SEL,
    output logic [REG_SEL_W-1:0] B_SEL,
    output logic [REG_SEL_W-1:0] DEST_SEL,
    output logic [OP_W-1:0]      OP_SEL,
    output logic [DATA_W-1:0]    CONST_IN,
    output logic                 CONST_SEL,
    output logic                 DATA_SEL,
    output logic                 LOAD_EN,
    output logic                 MEM_RE,
    output logic                 MEM_WE,
    input  logic                 MEM_READY,
    output logic                 HALTED
);

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic                 zflag_q, zflag_d;

    decoded_t             dec_c;
    logic [PC_W-1:0]      pc_inc_c;
    logic [PC_W-1:0]      br_off_c;
    logic [PC_W-1:0]      pc_br_c;

    instr_decoder u_instr_decoder (
        .ir    (ir_q),
        .dec_c (dec_c)
    );

    // Branch targets are relative to the next sequential address; all PC math wraps.
    assign pc_inc_c   = pc_q + PC_W'(1);
    assign br_off_c   = PC_W'($signed(dec_c.imm8));
    assign pc_br_c    = pc_inc_c + br_off_c;
    assign INSTR_ADDR = pc_q;

    // State, PC, IR and saved zero flag registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            zflag_q <= zflag_d;
        end
    end

    // Next-state, PC, IR and flag update
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        zflag_d = zflag_q;
        case (state_q)
            ST_FETCH: begin
                if (INSTR_VALID) begin
                    ir_d    = INSTR_IN;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (dec_c.cls)
                    CLS_ALU: begin
                        zflag_d = Z;
                        pc_d    = pc_inc_c;
                    end
                    CLS_LD:   state_d = ST_MEM_WAIT;
                    CLS_HALT: state_d = ST_HALT;
                    CLS_BZ:   pc_d = zflag_q ? pc_br_c : pc_inc_c;
                    CLS_BNZ:  pc_d = zflag_q ? pc_inc_c : pc_br_c;
                    CLS_JMP:  pc_d = PC_W'(dec_c.imm8);
                    default:  pc_d = pc_inc_c;
                endcase
            end
            ST_MEM_WAIT: begin
                if (MEM_READY) begin
                    pc_d    = pc_inc_c;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    // Control outputs decoded from state and IR
    always_comb begin
        INSTR_REQ = 1'b0;
        HALTED    = 1'b0;
        A_SEL     = '0;
        B_SEL     = '0;
        DEST_SEL  = '0;
        OP_SEL    = '0;
        CONST_IN  = '0;
        CONST_SEL = 1'b0;
        DATA_SEL  = 1'b0;
        LOAD_EN   = 1'b0;
        MEM_RE    = 1'b0;
        MEM_WE    = 1'b0;
        case (state_q)
            ST_FETCH: INSTR_REQ = 1'b1;
            ST_EXEC: begin
                case (dec_c.cls)
                    CLS_ALU: begin
                        A_SEL    = dec_c.ra;
                        B_SEL    = dec_c.rb;
                        DEST_SEL = dec_c.rd;
                        OP_SEL   = {1'b0, dec_c.alu_op};
                        LOAD_EN  = 1'b1;
                    end
                    CLS_LDI: begin
                        CONST_IN  = {8'h00, dec_c.imm8};
                        CONST_SEL = 1'b1;
                        OP_SEL    = OP_PASS_B;
                        DEST_SEL  = dec_c.rd;
                        LOAD_EN   = 1'b1;
                    end
                    CLS_LD: begin
                        A_SEL  = dec_c.ra;
                        MEM_RE = 1'b1;
                    end
                    CLS_ST: begin
                        A_SEL  = dec_c.ra;
                        B_SEL  = dec_c.rb;
                        MEM_WE = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM_WAIT: begin
                A_SEL  = dec_c.ra;
                MEM_RE = 1'b1;
                if (MEM_READY) begin
                    DATA_SEL = 1'b1;
                    DEST_SEL = dec_c.rd;
                    LOAD_EN  = 1'b1;
                end
            end
            default: HALTED = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_datapath_controller.sv
// Self-checking bench for datapath_controller: vector table, corner sequences, random stream.
module tb_datapath_controller;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  INSTR_ADDR;
    logic        INSTR_REQ;
    logic [15:0] INSTR_IN = '0;
    logic        INSTR_VALID = 1'b0;
    logic        Z = 1'b0;
    logic [3:0]  A_SEL, B_SEL, DEST_SEL, OP_SEL;
    logic [15:0] CONST_IN;
    logic        CONST_SEL, DATA_SEL, LOAD_EN, MEM_RE, MEM_WE;
    logic        MEM_READY = 1'b0;
    logic        HALTED;

    datapath_controller dut (
        .CLK         (CLK),
        .RST         (RST),
        .INSTR_ADDR  (INSTR_ADDR),
        .INSTR_REQ   (INSTR_REQ),
        .INSTR_IN    (INSTR_IN),
        .INSTR_VALID (INSTR_VALID),
        .Z           (Z),
        .A_SEL       (A_SEL),
        .B_SEL       (B_SEL),
        .DEST_SEL    (DEST_SEL),
        .OP_SEL      (OP_SEL),
        .CONST_IN    (CONST_IN),
        .CONST_SEL   (CONST_SEL),
        .DATA_SEL    (DATA_SEL),
        .LOAD_EN     (LOAD_EN),
        .MEM_RE      (MEM_RE),
        .MEM_WE      (MEM_WE),
        .MEM_READY   (MEM_READY),
        .HALTED      (HALTED)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  a, b, d, op;
        logic [15:0] cin;
        logic        cs, ds, le, we, re;
    } ctrl_t;

    typedef struct {
        logic [15:0] instr;
        logic        z;
        int          rdelay;
        ctrl_t       e;
        int          npc;
    } vec_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    exp_pc   = 0;
    ctrl_t idle_c;
    vec_t  tbl[16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic ctrl_t mk(input int a, input int b, input int d, input int op, input int cin,
                                 input int cs, input int ds, input int le, input int we, input int re);
        ctrl_t c;
        c.a = 4'(a); c.b = 4'(b); c.d = 4'(d); c.op = 4'(op); c.cin = 16'(cin);
        c.cs = 1'(cs); c.ds = 1'(ds); c.le = 1'(le); c.we = 1'(we); c.re = 1'(re);
        return c;
    endfunction

    task automatic check_ctrl(input string tag, input ctrl_t e);
        check({tag, ".a_sel"},     A_SEL,     e.a);
        check({tag, ".b_sel"},     B_SEL,     e.b);
        check({tag, ".dest_sel"},  DEST_SEL,  e.d);
        check({tag, ".op_sel"},    OP_SEL,    e.op);
        check({tag, ".const_in"},  CONST_IN,  e.cin);
        check({tag, ".const_sel"}, CONST_SEL, e.cs);
        check({tag, ".data_sel"},  DATA_SEL,  e.ds);
        check({tag, ".load_en"},   LOAD_EN,   e.le);
        check({tag, ".mem_we"},    MEM_WE,    e.we);
        check({tag, ".mem_re"},    MEM_RE,    e.re);
    endtask

    // ISA-level reference: expected EXEC controls, next PC and next zero flag.
    function automatic void model(input logic [15:0] instr, input logic z, input int pc, input logic zf,
                                  output ctrl_t c, output int npc, output logic nzf);
        int opc = int'(instr[15:12]);
        int rd  = int'(instr[11:8]);
        int ra  = int'(instr[7:4]);
        int rb  = int'(instr[3:0]);
        int imm = int'(instr[7:0]);
        int off = (imm >= 128) ? imm - 256 : imm;
        c   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        npc = (pc + 1) % 256;
        nzf = zf;
        if (opc < 8) begin
            c   = mk(ra, rb, rd, opc, 0, 0, 0, 1, 0, 0);
            nzf = z;
        end else if (opc == 8) begin
            c = mk(0, 0, rd, 12, imm, 1, 0, 1, 0, 0);
        end else if (opc == 9) begin
            c = mk(ra, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        end else if (opc == 10) begin
            c = mk(ra, rb, 0, 0, 0, 0, 0, 0, 1, 0);
        end else if ((opc == 11 && zf) || (opc == 12 && !zf)) begin
            npc = (pc + 1 + off + 256) % 256;
        end else if (opc == 13) begin
            npc = imm;
        end
    endfunction

    // One full instruction: optional fetch stall, EXEC, and for LD the memory wait.
    task automatic run_instr(input logic [15:0] instr, input logic z, input int fdelay,
                             input int rdelay, input ctrl_t e, input int next_pc);
        int    re_cycles;
        ctrl_t w;
        for (int i = 0; i < fdelay; i++) begin
            #2 INSTR_VALID = 1'b0; INSTR_IN = 16'($urandom); Z = 1'($urandom); MEM_READY = 1'($urandom);
            #1 check("fetch_stall.req", INSTR_REQ, 1);
            check("fetch_stall.addr", INSTR_ADDR, 32'(exp_pc));
            @(posedge CLK);
        end
        #2 INSTR_VALID = 1'b1; INSTR_IN = instr; MEM_READY = 1'($urandom);
        #1 check("fetch.req", INSTR_REQ, 1);
        check("fetch.addr", INSTR_ADDR, 32'(exp_pc));
        check_ctrl("fetch", idle_c);
        @(posedge CLK);
        #2 INSTR_VALID = 1'($urandom); INSTR_IN = 16'($urandom); Z = z; MEM_READY = 1'($urandom);
        #1 check("exec.req", INSTR_REQ, 0);
        check("exec.halted", HALTED, 0);
        check_ctrl("exec", e);
        re_cycles = int'(MEM_RE);
        @(posedge CLK);
        if (instr[15:12] == 4'h9) begin
            for (int i = 0; i <= rdelay; i++) begin
                #2 MEM_READY = (i == rdelay); INSTR_VALID = 1'($urandom);
                w = mk(int'(instr[7:4]), 0, 0, 0, 0, 0, 0, 0, 0, 1);
                if (i == rdelay) begin
                    w.d = instr[11:8]; w.ds = 1'b1; w.le = 1'b1;
                end
                #1 check("mem_wait.req", INSTR_REQ, 0);
                check_ctrl("mem_wait", w);
                re_cycles += int'(MEM_RE);
                @(posedge CLK);
            end
            check("ld.mem_re_cycles", 32'(re_cycles), 32'(rdelay + 2));
        end
        exp_pc = next_pc;
    endtask

    task automatic do_reset();
        #2 RST = 1'b1; INSTR_VALID = 1'b0; MEM_READY = 1'b0;
        @(posedge CLK);
        #2 RST = 1'b0;
        #1 check("reset.req", INSTR_REQ, 1);
        check("reset.addr", INSTR_ADDR, 0);
        check("reset.halted", HALTED, 0);
        check_ctrl("reset", idle_c);
        @(posedge CLK);
        exp_pc = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ctrl_t c;
        int    npc;
        logic  zf, nzf;
        logic [3:0] opc;

        idle_c = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[0]  = '{16'h8105, 1'b0, 0, mk(0, 0, 1, 12, 16'h0005, 1, 0, 1, 0, 0), 1};
        tbl[1]  = '{16'h0312, 1'b1, 0, mk(1, 2, 3, 0, 0, 0, 0, 1, 0, 0), 2};
        tbl[2]  = '{16'hA045, 1'b0, 0, mk(4, 5, 0, 0, 0, 0, 0, 0, 1, 0), 3};
        tbl[3]  = '{16'hB0FE, 1'b0, 0, idle_c, 2};
        tbl[4]  = '{16'h1234, 1'b0, 0, mk(3, 4, 2, 1, 0, 0, 0, 1, 0, 0), 3};
        tbl[5]  = '{16'hB0FE, 1'b1, 0, idle_c, 4};
        tbl[6]  = '{16'hC005, 1'b0, 0, idle_c, 10};
        tbl[7]  = '{16'h7ABC, 1'b1, 0, mk(11, 12, 10, 7, 0, 0, 0, 1, 0, 0), 11};
        tbl[8]  = '{16'hC0FF, 1'b0, 0, idle_c, 12};
        tbl[9]  = '{16'hB080, 1'b0, 0, idle_c, 141};
        tbl[10] = '{16'hD0FF, 1'b0, 0, idle_c, 255};
        tbl[11] = '{16'hF000, 1'b0, 0, idle_c, 0};
        tbl[12] = '{16'hD010, 1'b0, 0, idle_c, 16};
        tbl[13] = '{16'h8AFF, 1'b0, 0, mk(0, 0, 10, 12, 16'h00FF, 1, 0, 1, 0, 0), 17};
        tbl[14] = '{16'h9270, 1'b0, 1, mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 1), 18};
        tbl[15] = '{16'h9345, 1'b0, 0, mk(4, 0, 0, 0, 0, 0, 0, 0, 0, 1), 19};

        // Asynchronous reset seen before any clock edge
        #1 RST = 1'b1;
        #1 check("async_reset.req", INSTR_REQ, 1);
        check("async_reset.addr", INSTR_ADDR, 0);
        check_ctrl("async_reset", idle_c);
        @(posedge CLK);
        do_reset();

        // Directed vector table
        for (int i = 0; i < 16; i++)
            run_instr(tbl[i].instr, tbl[i].z, i % 2, tbl[i].rdelay, tbl[i].e, tbl[i].npc);
        #2 INSTR_VALID = 1'b0;
        #1 check("table_end.addr", INSTR_ADDR, 32'(exp_pc));
        @(posedge CLK);

        // Reset while waiting on a load: read request drops at once, nothing written
        #2 INSTR_VALID = 1'b1; INSTR_IN = 16'h9270;
        @(posedge CLK);
        #2 INSTR_VALID = 1'b0; MEM_READY = 1'b0;
        @(posedge CLK);
        #2 MEM_READY = 1'b0;
        #1 check("ld_rst.pre_mem_re", MEM_RE, 1);
        #1 RST = 1'b1; MEM_READY = 1'b1;
        #1 check("ld_rst.mem_re", MEM_RE, 0);
        check("ld_rst.load_en", LOAD_EN, 0);
        check("ld_rst.data_sel", DATA_SEL, 0);
        check("ld_rst.addr", INSTR_ADDR, 0);
        check("ld_rst.req", INSTR_REQ, 1);
        @(posedge CLK);
        #2 RST = 1'b0; MEM_READY = 1'b0;
        #1 check("ld_rst.after_addr", INSTR_ADDR, 0);
        @(posedge CLK);
        exp_pc = 0;

        // Random instruction stream against the ISA model (HALT excluded)
        zf = 1'b0;
        for (int n = 0; n < 300; n++) begin
            opc = 4'($urandom_range(0, 14));
            if (opc == 4'hE) opc = 4'hF;
            INSTR_IN = 16'h0;
            model({opc, 12'($urandom)}, 1'($urandom), exp_pc, zf, c, npc, nzf);
            begin
                logic [15:0] ins;
                logic        zz;
                ins = {opc, 12'($urandom)};
                zz  = 1'($urandom);
                model(ins, zz, exp_pc, zf, c, npc, nzf);
                run_instr(ins, zz, $urandom_range(0, 2), $urandom_range(0, 3), c, npc);
            end
            zf = nzf;
        end

        // HALT is terminal until reset
        run_instr(16'hE000, 1'b0, 0, 0, idle_c, exp_pc);
        for (int i = 0; i < 20; i++) begin
            #2 INSTR_VALID = 1'($urandom); INSTR_IN = 16'($urandom); MEM_READY = 1'($urandom);
            #1 check("halt.halted", HALTED, 1);
            check("halt.req", INSTR_REQ, 0);
            check("halt.addr", INSTR_ADDR, 32'(exp_pc));
            check_ctrl("halt", idle_c);
            @(posedge CLK);
        end
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
